serial_comparator: RTL and testbench
====================================

// Module: serial_comparator
//
// PURPOSE
//   Bit-serial magnitude comparator. It compares two WIDTH-bit operands that arrive
//   MSB-first, one bit pair per valid cycle, and issues a registered eq/gt/lt verdict.
//   Each bit pair gets a per-bit equal/greater/less decision, with the first
//   differing bit latched. Sits downstream of serialisers / shift registers feeding a_bit/b_bit.
//
// PARAMETERS
//   WIDTH  8  operand width in bits (>=1); number of bit pairs per comparison
//
// PORTS
//   clk        in   1  clock, rising edge
//   rst_n      in   1  synchronous reset, active low
//   start      in   1  begin new comparison (accepted in IDLE only)
//   bit_valid  in   1  a_bit/b_bit valid this cycle
//   a_bit      in   1  operand A bit, MSB first
//   b_bit      in   1  operand B bit, MSB first
//   busy       out  1  comparison in progress (RUN state)
//   done       out  1  one-cycle pulse: eq/gt/lt just updated
//   eq         out  1  A == B (registered, held until next done)
//   gt         out  1  A >  B
//   lt         out  1  A <  B
//
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): state=IDLE.
//     - Outputs: busy=0, done=0, eq=0, gt=0, lt=0.
//     - Internal bit counter and decision flags are cleared.
//     - Reset mid-RUN aborts the comparison; no done is issued.
//   - FSM states: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE:
//     - start=1: go to RUN; cnt=0; internal dec_gt=0, dec_lt=0.
//     - bit_valid is ignored, including on the same cycle as start.
//   - RUN (busy=1):
//     - Each cycle with bit_valid=1: cnt++.
//     - If no decision yet: a_bit=1,b_bit=0 -> dec_gt=1; a_bit=0,b_bit=1 -> dec_lt=1.
//     - Once decided, later bits never change dec_gt/dec_lt.
//     - bit_valid=0 cycles (gaps) stall; the state is held.
//     - After the WIDTH-th valid bit: go to DONE.
//   - DONE (one cycle):
//     - done=1, busy=0.
//     - eq = ~dec_gt & ~dec_lt; gt = dec_gt; lt = dec_lt. Exactly one of the three is 1.
//     - Then go to IDLE; eq/gt/lt hold until the next done.
//   - Latency: last valid bit at cycle L -> done=1 and result visible at cycle L+1.
//     Minimum start-to-done = WIDTH+1 cycles.
//   - start while in RUN or DONE is ignored; no queuing.
//   - Counter: $clog2(WIDTH+1) bits; no wrap inside a comparison.
//     WIDTH=1 behaves as a single registered 1-bit compare.
//
// CONFIGURATION
//   Macro: SERIAL_CMP_EARLY_EXIT_EN
//   - Defined: when dec_gt or dec_lt is first set on valid bit k < WIDTH,
//     the FSM goes to DONE on the next cycle.
//     - done/gt/lt are issued without consuming the remaining bits.
//     - Upstream must discard its residual bits on done.
//     - The eq verdict still requires all WIDTH bits.
//   - Undefined: exactly WIDTH valid bits are always consumed per comparison.
//
// TESTING (WIDTH=8)
//   1. Reset; A=0xA5, B=0xA5, 8 contiguous valid bits -> done at cycle L+1;
//      eq=1, gt=0, lt=0; busy low in DONE.
//   2. A=0x80, B=0x7F -> gt=1, eq=0, lt=0.
//      With EARLY_EXIT_EN: done 1 cycle after the first bit.
//      Without: done after the 8th bit.
//   3. A=0x3C, B=0x3D with bit_valid gaps (valid every other cycle) -> lt=1;
//      done one cycle after the 8th valid bit.
//   4. start pulsed in mid-RUN and during DONE -> ignored; the result matches
//      the first operands only.
//   5. rst_n=0 after 4 bits of A=0xFF, B=0x00 -> all outputs 0, no done;
//      a new compare of 0x00 vs 0x01 -> lt=1.
//   6. Back-to-back: start in the IDLE cycle after done; A=0x01, B=0x00 -> gt=1.
//      Previous eq/gt/lt hold until the new done.

Source files
------------

// File: rtl/serial_comparator.sv
// serial_comparator: bit-serial MSB-first magnitude comparator with a registered
// eq/gt/lt verdict and a one-cycle done pulse.
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN (finish as soon as the first
// differing bit pair decides gt/lt instead of always consuming WIDTH bits).
module serial_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic eq,
  output logic gt,
  output logic lt
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             dec_gt;
  logic             dec_gt_next;
  logic             dec_lt;
  logic             dec_lt_next;
  logic             decided;

  assign decided = dec_gt | dec_lt;

  // Next-state, bit counter and first-difference decision logic
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    dec_gt_next = dec_gt;
    dec_lt_next = dec_lt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = RUN;
          cnt_next    = '0;
          dec_gt_next = 1'b0;
          dec_lt_next = 1'b0;
        end
      end
      RUN: begin
        if (bit_valid) begin
          cnt_next = cnt + CNT_W'(1);
          // The first differing bit pair fixes the verdict for the rest of the word
          if (!decided) begin
            dec_gt_next = a_bit & ~b_bit;
            dec_lt_next = ~a_bit & b_bit;
          end
          if (cnt == LAST_IDX) begin
            state_next = DONE;
          end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          else if (!decided && (a_bit ^ b_bit)) begin
            state_next = DONE;
          end
`endif
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus registered status and verdict outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dec_gt <= 1'b0;
      dec_lt <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
      lt     <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      dec_gt <= dec_gt_next;
      dec_lt <= dec_lt_next;
      busy   <= (state_next == RUN);
      done   <= (state_next == DONE);
      if (state_next == DONE) begin
        eq <= ~dec_gt_next & ~dec_lt_next;
        gt <= dec_gt_next;
        lt <= dec_lt_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: randomized and directed stimulus for serial_comparator,
// checked every cycle against a word-level reference model.
module tb_serial_comparator;

  localparam int unsigned W = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic eq;
  logic gt;
  logic lt;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model state: operand prefixes collected so far, compared as integers
  int          m_phase = 0;
  int unsigned m_a = 0;
  int unsigned m_b = 0;
  int unsigned m_n = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_eq = 1'b0;
  logic        m_gt = 1'b0;
  logic        m_lt = 1'b0;

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_phase = 0;
      m_done  = 1'b0;
      m_eq    = 1'b0;
      m_gt    = 1'b0;
      m_lt    = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_a = 0;
          m_b = 0;
          m_n = 0;
        end
        1: if (bit_valid) begin
          m_a = (m_a << 1) | 32'(a_bit);
          m_b = (m_b << 1) | 32'(b_bit);
          m_n++;
          if (m_n == W || (EARLY && m_a != m_b)) begin
            m_phase = 2;
            m_done  = 1'b1;
            m_eq    = (m_a == m_b);
            m_gt    = (m_a > m_b);
            m_lt    = (m_a < m_b);
          end
        end
        default: m_phase = 0;
      endcase
    end
    m_busy = (m_phase == 1);
  endtask

  // One comparison: start, feed MSB-first bits (gap<0 means random gaps), wait for done
  task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                        input bit pulse, input int exp_code, input int exp_bits,
                        input string name);
    int used;
    bit seen;
    int g;
    @(negedge clk);
    start     = 1'b1;
    bit_valid = 1'b1;
    a_bit     = 1'($urandom);
    b_bit     = 1'($urandom);
    @(negedge clk);
    start     = 1'b0;
    bit_valid = 1'b0;
    used = 0;
    seen = 1'b0;
    for (int i = int'(W) - 1; i >= 0 && !seen; i--) begin
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      repeat (g) begin
        bit_valid = 1'b0;
        a_bit     = 1'($urandom);
        b_bit     = 1'($urandom);
        @(negedge clk);
      end
      bit_valid = 1'b1;
      a_bit     = a[i];
      b_bit     = b[i];
      start     = pulse && (i == int'(W / 2));
      @(negedge clk);
      used++;
      bit_valid = 1'b0;
      start     = 1'b0;
      if (done) seen = 1'b1;
    end
    for (int t = 0; t < 4 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
    check({name, " busy low in DONE"}, 32'(busy), 32'd0);
    if (exp_bits > 0) check({name, " bits to done"}, 32'(used), 32'(exp_bits));
    if (exp_code >= 0) check({name, " verdict"}, 32'({eq, gt, lt}), 32'(exp_code));
    if (pulse) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, " start in DONE ignored busy"}, 32'(busy), 32'd0);
      if (exp_code >= 0) check({name, " verdict held"}, 32'({eq, gt, lt}), 32'(exp_code));
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int code;
    rst_n     = 1'b0;
    start     = 1'b0;
    bit_valid = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;

    fork
      forever begin
        @(posedge clk);
        model_step();
      end
      forever begin
        @(negedge clk);
        if (mon_en)
          check("cycle outputs {busy,done,eq,gt,lt}", 32'({busy, done, eq, gt, lt}),
                32'({m_busy, m_done, m_eq, m_gt, m_lt}));
      end
      begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, %0d checks", checks);
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check("reset outputs", 32'({busy, done, eq, gt, lt}), 32'd0);
    rst_n = 1'b1;

    // Equal operands, contiguous bits
    do_cmp(8'hA5, 8'hA5, 0, 1'b0, 3'b100, 8, "t1 A5 vs A5");
    // MSB decides greater
    do_cmp(8'h80, 8'h7F, 0, 1'b0, 3'b010, EARLY ? 1 : 8, "t2 80 vs 7F");
    // LSB decides less, valid every other cycle
    do_cmp(8'h3C, 8'h3D, 1, 1'b0, 3'b001, 8, "t3 3C vs 3D gaps");
    // start pulsed mid-RUN and in DONE is ignored
    do_cmp(8'h4D, 8'h4C, 0, 1'b1, 3'b010, 8, "t4 4D vs 4C pulses");

    // Reset partway through a comparison aborts it
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      a_bit     = 1'b1;
      b_bit     = 1'b0;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5 outputs after mid-run reset", 32'({busy, done, eq, gt, lt}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5 no done after abort", 32'({busy, done}), 32'd0);
    end
    bit_valid = 1'b0;
    do_cmp(8'h00, 8'h01, 0, 1'b0, 3'b001, 8, "t5 00 vs 01");
    // Back-to-back: next start lands in the IDLE cycle right after done
    do_cmp(8'h01, 8'h00, 0, 1'b0, 3'b010, 8, "t6 01 vs 00");
    do_cmp(8'hFF, 8'hFF, 0, 1'b0, 3'b100, 8, "t6 FF vs FF");

    // Randomized operands, gaps and idle noise
    for (int r = 0; r < 40; r++) begin
      ra = W'($urandom);
      case (r % 4)
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(W - 1, 0));
        default: rb = W'($urandom);
      endcase
      code = (ra == rb) ? 4 : ((ra > rb) ? 2 : 1);
      do_cmp(ra, rb, -1, 1'(r % 5 == 0), code, -1, "rand");
      repeat ($urandom_range(2, 0)) begin
        bit_valid = 1'($urandom);
        a_bit     = 1'($urandom);
        b_bit     = 1'($urandom);
        @(negedge clk);
      end
      bit_valid = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
